// File: rtl/fp_arb_pkg.sv
// Shared definitions for the fp_adder arbiter: data widths, the default
// watchdog limit and the sequencer state encoding.
package fp_arb_pkg;

    localparam int DATA_W          = 32;
    localparam int FLAGS_W         = 5;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_adder_arbiter_rr_pick.sv
// Round-robin pick: finds the first asserted request at or above ptr,
// wrapping past N_REQ-1 back to 0.
// Ports:
//   req   - request vector
//   ptr   - search start index (always < N_REQ)
//   grant - one-hot winner, all zero when no request is asserted
//   gidx  - index of the winner, 0 when no request is asserted
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] gidx
);

    logic             found;
    logic [IDX_W:0]   idx_ext;

    always_comb begin
        grant   = '0;
        gidx    = '0;
        found   = 1'b0;
        idx_ext = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx_ext = {1'b0, ptr} + (IDX_W+1)'(off);
            // ptr < N_REQ, so a single subtraction is enough to wrap.
            if (idx_ext >= (IDX_W+1)'(N_REQ)) begin
                idx_ext = idx_ext - (IDX_W+1)'(N_REQ);
            end
            if (!found && req[idx_ext[IDX_W-1:0]]) begin
                found                       = 1'b1;
                grant[idx_ext[IDX_W-1:0]]   = 1'b1;
                gidx                        = idx_ext[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one fp_adder between N_REQ requesters. A round-robin grant is taken
// in IDLE, operands are latched, a single start pulse is issued, the adder's
// valid_out is awaited under a watchdog and the result is returned to the
// granted requester.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. req_ready is only offered in IDLE, to the granted
// requester; resp_valid stays asserted with stable result/flags/timeout until
// the granted requester's resp_ready is seen.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   req_valid/req_ready           - per-requester request handshake
//   req_op_a/req_op_b             - packed operands, requester i at [32i+31:32i]
//   req_mode_fp/req_round_mode    - per-requester adder controls
//   resp_valid/resp_ready         - one-hot response handshake
//   resp_result/flags/timeout     - response payload
//   adder_*                       - connection to the shared fp_adder
//   dbg_state/dbg_rr_ptr          - sequencer state and round-robin pointer
module fp_adder_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [DATA_W*N_REQ-1:0]   req_op_a,
    input  logic [DATA_W*N_REQ-1:0]   req_op_b,
    input  logic [N_REQ-1:0]          req_mode_fp,
    input  logic [N_REQ-1:0]          req_round_mode,
    output logic [N_REQ-1:0]          resp_valid,
    input  logic [N_REQ-1:0]          resp_ready,
    output logic [DATA_W-1:0]         resp_result,
    output logic [FLAGS_W-1:0]        resp_flags,
    output logic                      resp_timeout,
    output logic                      adder_start,
    output logic [DATA_W-1:0]         adder_op_a,
    output logic [DATA_W-1:0]         adder_op_b,
    output logic                      adder_mode_fp,
    output logic                      adder_round_mode,
    output logic                      adder_ready,
    input  logic                      adder_valid,
    input  logic [DATA_W-1:0]         adder_result,
    input  logic [FLAGS_W-1:0]        adder_flags,
    output state_t                    dbg_state,
    output logic [IDX_W-1:0]          dbg_rr_ptr
);

    state_t             state, state_n;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   g_q;
    logic [CNT_W-1:0]   cnt;
    logic [N_REQ-1:0]   grant;
    logic [IDX_W-1:0]   gidx;
    logic               timeout_hit;
    logic               resp_hs;

    logic [DATA_W-1:0]  op_a_arr [N_REQ];
    logic [DATA_W-1:0]  op_b_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign op_a_arr[i] = req_op_a[i*DATA_W +: DATA_W];
        assign op_b_arr[i] = req_op_b[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .gidx  (gidx)
    );

    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    // Only the granted requester's resp_ready completes the response.
    assign resp_hs     = resp_ready[g_q];

    always_comb begin
        state_n     = state;
        req_ready   = '0;
        resp_valid  = '0;
        adder_start = 1'b0;
        adder_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = grant;
                if (|req_valid) state_n = ST_ISSUE;
            end
            ST_ISSUE: begin
                adder_start = 1'b1;
                state_n     = ST_WAIT;
            end
            ST_WAIT: begin
                adder_ready = 1'b1;
                if (adder_valid || timeout_hit) state_n = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = N_REQ'(1) << g_q;
                if (resp_hs) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            rr_ptr           <= '0;
            g_q              <= '0;
            cnt              <= '0;
            resp_result      <= '0;
            resp_flags       <= '0;
            resp_timeout     <= 1'b0;
            adder_op_a       <= '0;
            adder_op_b       <= '0;
            adder_mode_fp    <= 1'b0;
            adder_round_mode <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        g_q              <= gidx;
                        adder_op_a       <= op_a_arr[gidx];
                        adder_op_b       <= op_b_arr[gidx];
                        adder_mode_fp    <= req_mode_fp[gidx];
                        adder_round_mode <= req_round_mode[gidx];
                    end
                end
                ST_ISSUE: begin
                    cnt <= '0;
                end
                ST_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    // A real result on the last watchdog cycle beats the timeout.
                    if (adder_valid) begin
                        resp_result  <= adder_result;
                        resp_flags   <= adder_flags;
                        resp_timeout <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_result  <= '0;
                        resp_flags   <= '0;
                        resp_timeout <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_hs) begin
                        rr_ptr <= (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

endmodule

// File: doc/fp_adder_arbiter.md
# fp_adder_arbiter

- Round-robin arbiter and sequencer that shares one `fp_adder` instance between `N_REQ` requesters.
- Each requester presents operands and rounding/mode controls through a valid/ready handshake.
- The block issues a single `start` pulse to the adder, waits for `valid_out` with a watchdog, and returns `result`/`flags` to the granted requester on a response handshake.
- It sits between requester logic (board-level test sequencer, later a CPU-side port) and the adder, and replaces direct `start` driving.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 64: max cycles waiting for adder `valid_out` before forced completion (≥2).

Ports:
- `clk` in 1: single clock for the block and the adder.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: per-requester accept; at most one bit high.
- `req_op_a` in 32·N_REQ: operand A, requester i at bits [32i+31:32i].
- `req_op_b` in 32·N_REQ: operand B, same packing.
- `req_mode_fp` in N_REQ: mode select per requester.
- `req_round_mode` in N_REQ: rounding mode per requester.
- `resp_valid` out N_REQ: one-hot response valid.
- `resp_ready` in N_REQ: per-requester response accept.
- `resp_result` out 32: result for the requester flagged in `resp_valid`.
- `resp_flags` out 5: adder flags.
- `resp_timeout` out 1: response was forced by the watchdog.
- `adder_start` out 1: one-cycle start pulse.
- `adder_op_a` out 32: operand A to the adder.
- `adder_op_b` out 32: operand B to the adder.
- `adder_mode_fp` out 1: mode to the adder.
- `adder_round_mode` out 1: rounding mode to the adder.
- `adder_ready` out 1: to adder `ready_in`.
- `adder_valid` in 1: from adder `valid_out`.
- `adder_result` in 32: from adder `result`.
- `adder_flags` in 5: from adder `flags`.

## Operation

States: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Grant `g` is the first requester with `req_valid` high, searching from `rr_ptr` upward with wrap.
  - `req_ready[g]` is driven combinationally, only in IDLE.
  - On handshake: latch operands, mode and rounding from requester g into registers; store g; go to ISSUE.
  - No valid request: stay in IDLE.
- **ISSUE**
  - `adder_start`=1 for exactly this cycle; `adder_*` operand outputs come from registers.
  - Clear the watchdog counter; go to WAIT.
- **WAIT**
  - `adder_ready`=1; counter increments each cycle.
  - `adder_valid` high: capture `adder_result`/`adder_flags`, `resp_timeout`=0, go to RESP.
  - Else, counter == TIMEOUT-1: result=0, flags=0, `resp_timeout`=1, go to RESP.
  - `adder_valid` and timeout in the same cycle: the valid result wins.
- **RESP**
  - `resp_valid[g]`=1; result, flags and timeout are held stable.
  - On `resp_ready[g]`: `rr_ptr` ← (g+1) mod N_REQ, go to IDLE.
  - `resp_ready` bits other than g are ignored.
- `adder_valid` outside WAIT is ignored and the registers are unchanged.
- `req_valid` deasserting before handshake has no effect; requests are never dropped once accepted.
- `adder_*` operand outputs hold their last issued values between operations.

## Timing

- Reset values:
  - state=IDLE, `rr_ptr`=0, counter=0.
  - `req_ready`=0, `resp_valid`=0, `resp_result`=0, `resp_flags`=0, `resp_timeout`=0.
  - `adder_start`=0, `adder_ready`=0, all `adder_*` operand outputs 0.
- Reset mid-operation abandons the operation with no response. The adder must be reset by the same `rst`.
- Latency, with request accepted at cycle 0:
  - `adder_start` at cycle 1.
  - If `adder_valid` arrives at cycle k (k≥2), `resp_valid` rises at k+1.
  - Timeout: `resp_valid` rises at cycle TIMEOUT+2.
- Throughput:
  - The next grant is possible in the cycle after the response handshake.
  - Minimum period per operation is adder latency + 3 cycles.
  - One operation is in flight at a time.
- Fairness: a continuously requesting requester waits at most N_REQ-1 operations.

## Structure

- **Package `fp_arb_pkg`** holds:
  - The state enum.
  - `DATA_W`=32 and `FLAGS_W`=5.
  - `TIMEOUT` default.
- **Sub-module `rr_pick`** (combinational): inputs `req`[N_REQ] and `ptr`; outputs one-hot `grant` and index `gidx`.
- **Top FSM, registers and watchdog** live in `fp_adder_arbiter`.

## Test plan

- **Single request:** requester 2, op_a=0x3F800000, op_b=0x40000000, mode_fp=1; adder model returns 0x40400000, flags 0 after 3 cycles. Expect `adder_start` at cycle 1, `resp_valid`=4'b0100 at cycle 5, result 0x40400000, `resp_timeout`=0.
- **Round-robin:** all four `req_valid` held high for 8 operations. Expect grant order 0,1,2,3,0,1,2,3 and `rr_ptr` back at 0.
- **Watchdog:** adder model never asserts valid, TIMEOUT=8. Expect response at cycle 10 with result 0, flags 0, `resp_timeout`=1.
- **Response backpressure:** `resp_ready` held low 5 cycles while other requesters are valid. Expect `resp_valid`/result stable, no new `req_ready`, and the next grant the cycle after handshake.
- **Stray and simultaneous valid:**
  - `adder_valid` pulse during IDLE: no state change.
  - `adder_valid` on the counter's last cycle: real result, `resp_timeout`=0.
- **Reset in WAIT:** assert `rst` 1 cycle. Expect all outputs at reset values next cycle, `rr_ptr`=0, and a new request accepted normally.
